perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 181 ++++++++++++++++++
 tb/tb_perf_counter_bank.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Bank of event-selectable performance counters on a simple io bus.
// Each counter picks one event line, counts its pulses while enabled,
// wraps with a sticky overflow flag and can raise a level interrupt.
// COUNT_LO reads latch the upper bits so software gets an atomic wide read.
module perf_counter_bank #(
  parameter int          NUM_EVENTS    = 16,
  parameter int          NUM_COUNTERS  = 4,
  parameter int          COUNTER_WIDTH = 48,
  parameter logic [31:0] BASE_ADDRESS  = 32'h0011_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] perf_events,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  overflow_irq
);

  localparam int          HI_WIDTH = COUNTER_WIDTH - 32;
  localparam logic [4:0]  NUM_CTR  = 5'(NUM_COUNTERS);
  localparam logic [31:0] ID_VALUE = {8'(COUNTER_WIDTH), 8'(NUM_COUNTERS),
                                      8'(NUM_EVENTS), 8'h01};

  // Per-counter state
  logic [5:0]               event_sel_reg [NUM_COUNTERS];
  logic                     count_en_reg  [NUM_COUNTERS];
  logic                     irq_en_reg    [NUM_COUNTERS];
  logic                     ovf_flag_reg  [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] count_reg     [NUM_COUNTERS];

  // Shared snapshot of the upper bits taken on a COUNT_LO read
  logic [HI_WIDTH-1:0] snap_reg;
  logic                snap_valid_reg;
  logic [3:0]          snap_idx_reg;

  logic [NUM_COUNTERS-1:0] ovf_vec;
  logic [NUM_COUNTERS-1:0] irq_en_vec;

  // Address decode
  logic       block_hit;
  logic [8:0] offset;
  logic [3:0] ctr_idx;
  logic [1:0] reg_sel;
  logic       ctr_hit;
  logic       ovf_hit;
  logic       id_hit;
  logic       lo_read;

  assign block_hit = (address[31:9] == BASE_ADDRESS[31:9]);
  assign offset    = address[8:0];
  assign ctr_idx   = offset[7:4];
  assign reg_sel   = offset[3:2];
  assign ctr_hit   = block_hit && !offset[8] && (offset[1:0] == 2'b00) &&
                     ({1'b0, ctr_idx} < NUM_CTR);
  assign ovf_hit   = block_hit && (offset == 9'h100);
  assign id_hit    = block_hit && (offset == 9'h104);
  assign lo_read   = read_en && ctr_hit && (reg_sel == 2'd2);

  // Event lines padded to the full select range: selects past NUM_EVENTS see 0
  logic [63:0] events_padded;
  assign events_padded = 64'(perf_events);

  for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_ctr
    logic wr_this;
    logic wr_count;
    logic inc;
    logic wraps;
    logic clr_ovf;

    assign wr_this  = write_en && ctr_hit && (ctr_idx == 4'(gi));
    assign wr_count = wr_this && reg_sel[1];
    assign inc      = count_en_reg[gi] && events_padded[event_sel_reg[gi]];
    assign wraps    = &count_reg[gi];
    assign clr_ovf  = write_en && ovf_hit && write_data[gi];

    // Config registers, counter (software writes beat events) and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        event_sel_reg[gi] <= '0;
        count_en_reg[gi]  <= 1'b0;
        irq_en_reg[gi]    <= 1'b0;
        count_reg[gi]     <= '0;
        ovf_flag_reg[gi]  <= 1'b0;
      end else begin
        if (wr_this && reg_sel == 2'd0) begin
          event_sel_reg[gi] <= write_data[5:0];
        end
        if (wr_this && reg_sel == 2'd1) begin
          count_en_reg[gi] <= write_data[0];
          irq_en_reg[gi]   <= write_data[1];
        end
        if (wr_this && reg_sel == 2'd2) begin
          count_reg[gi][31:0] <= write_data;
        end else if (wr_this && reg_sel == 2'd3) begin
          count_reg[gi][COUNTER_WIDTH-1:32] <= write_data[HI_WIDTH-1:0];
        end else if (inc) begin
          count_reg[gi] <= count_reg[gi] + COUNTER_WIDTH'(1);
        end
        // A fresh wrap wins over a simultaneous clear so no overflow is lost
        if (inc && wraps && !wr_count) begin
          ovf_flag_reg[gi] <= 1'b1;
        end else if (clr_ovf) begin
          ovf_flag_reg[gi] <= 1'b0;
        end
      end
    end

    assign ovf_vec[gi]    = ovf_flag_reg[gi];
    assign irq_en_vec[gi] = irq_en_reg[gi];
  end

  // Select the addressed counter's state for the read mux
  logic [5:0]               sel_event;
  logic                     sel_en;
  logic                     sel_irq_en;
  logic [COUNTER_WIDTH-1:0] sel_count;
  logic [HI_WIDTH-1:0]      hi_value;
  logic [31:0]              read_value;

  // Read mux; unmapped locations and misses return zero
  always_comb begin
    sel_event  = '0;
    sel_en     = 1'b0;
    sel_irq_en = 1'b0;
    sel_count  = '0;
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      if (ctr_idx == 4'(n)) begin
        sel_event  = event_sel_reg[n];
        sel_en     = count_en_reg[n];
        sel_irq_en = irq_en_reg[n];
        sel_count  = count_reg[n];
      end
    end
    hi_value = (snap_valid_reg && snap_idx_reg == ctr_idx) ?
               snap_reg : sel_count[COUNTER_WIDTH-1:32];
    read_value = '0;
    if (ctr_hit) begin
      case (reg_sel)
        2'd0:    read_value = {26'd0, sel_event};
        2'd1:    read_value = {30'd0, sel_irq_en, sel_en};
        2'd2:    read_value = sel_count[31:0];
        default: read_value = 32'(hi_value);
      endcase
    end else if (ovf_hit) begin
      read_value = 32'(ovf_vec);
    end else if (id_hit) begin
      read_value = ID_VALUE;
    end
  end

  // Registered read data plus snapshot tracking: only a COUNT_LO read arms it,
  // any other read disarms it so a lone COUNT_HI read sees live bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data      <= '0;
      snap_reg       <= '0;
      snap_valid_reg <= 1'b0;
      snap_idx_reg   <= '0;
    end else if (read_en) begin
      read_data      <= read_value;
      snap_valid_reg <= lo_read;
      if (lo_read) begin
        snap_reg     <= sel_count[COUNTER_WIDTH-1:32];
        snap_idx_reg <= ctr_idx;
      end
    end
  end

  // Level interrupt, registered one cycle behind the flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_irq <= 1'b0;
    end else begin
      overflow_irq <= |(ovf_vec & irq_en_vec);
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomized and directed bench for perf_counter_bank with a behavioural model.
module tb_perf_counter_bank;

  localparam logic [31:0] B = 32'h0011_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] perf_events = '0;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        overflow_irq;

  perf_counter_bank #(
    .NUM_EVENTS(16), .NUM_COUNTERS(4), .COUNTER_WIDTH(48), .BASE_ADDRESS(B)
  ) dut (
    .clk(clk), .reset(reset), .perf_events(perf_events),
    .write_en(write_en), .read_en(read_en), .address(address),
    .write_data(write_data), .read_data(read_data), .overflow_irq(overflow_irq)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [47:0] m_count [4];
  int          m_sel   [4];
  bit          m_en    [4];
  bit          m_irqen [4];
  bit          m_ovf   [4];
  logic [15:0] m_snap;
  bit          m_snap_valid;
  int          m_snap_idx;
  logic [31:0] exp_rd;
  bit          exp_irq;

  int  passes = 0;
  int  total  = 0;
  bit  chk_en = 1'b0;

  // Literal-expectation requests handed to the compare process
  int          lit_req_seq = 0;
  string       lit_name;
  logic [31:0] lit_exp;
  bit          lit_is_irq;

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_count[n] = '0; m_sel[n] = 0; m_en[n] = 0; m_irqen[n] = 0; m_ovf[n] = 0;
    end
    m_snap = '0; m_snap_valid = 0; m_snap_idx = 0;
    exp_rd = '0; exp_irq = 0;
  endtask

  // One clock edge of the register map described in plain arithmetic
  task automatic model_step(input bit we, input bit re, input logic [31:0] a,
                            input logic [31:0] d, input logic [15:0] ev);
    bit          hit;
    int          off;
    int          idx;
    int          r;
    logic [31:0] rv;
    bit          nxt_irq;
    bit          counted [4];
    bit          ovf_new;
    logic [48:0] sum;
    hit = (a[31:9] == B[31:9]);
    off = int'(a[8:0]);
    idx = -1;
    r   = 0;
    if (hit && off < 256 && off % 4 == 0 && off / 16 < 4) begin
      idx = off / 16;
      r   = (off % 16) / 4;
    end
    nxt_irq = 0;
    for (int n = 0; n < 4; n++) begin
      if (m_ovf[n] && m_irqen[n]) nxt_irq = 1;
      counted[n] = 0;
      if (m_en[n] && m_sel[n] < 16) counted[n] = ev[m_sel[n]];
    end
    if (re) begin
      rv = '0;
      if (idx >= 0) begin
        case (r)
          0: rv = 32'(m_sel[idx]);
          1: rv = {30'd0, m_irqen[idx], m_en[idx]};
          2: rv = m_count[idx][31:0];
          default: rv = (m_snap_valid && m_snap_idx == idx) ?
                        {16'd0, m_snap} : {16'd0, m_count[idx][47:32]};
        endcase
      end else if (hit && off == 256) begin
        for (int n = 0; n < 4; n++) rv[n] = m_ovf[n];
      end else if (hit && off == 260) begin
        rv = 32'h3004_1001;
      end
      exp_rd = rv;
      if (idx >= 0 && r == 2) begin
        m_snap_valid = 1; m_snap_idx = idx; m_snap = m_count[idx][47:32];
      end else begin
        m_snap_valid = 0;
      end
    end
    for (int n = 0; n < 4; n++) begin
      ovf_new = 0;
      if (we && idx == n && r == 0) m_sel[n] = int'(d[5:0]);
      if (we && idx == n && r == 1) begin m_en[n] = d[0]; m_irqen[n] = d[1]; end
      if (we && idx == n && r == 2) m_count[n][31:0] = d;
      else if (we && idx == n && r == 3) m_count[n][47:32] = d[15:0];
      else if (counted[n]) begin
        sum = {1'b0, m_count[n]} + 49'd1;
        m_count[n] = sum[47:0];
        ovf_new = sum[48];
      end
      if (ovf_new) m_ovf[n] = 1;
      else if (we && hit && off == 256 && d[n]) m_ovf[n] = 0;
    end
    exp_irq = nxt_irq;
  endtask

  // Compare process: model vs DUT every cycle, plus pending literal checks
  initial begin
    int          lit_done_seq;
    logic [31:0] got;
    lit_done_seq = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        total++;
        if (read_data === exp_rd) passes++;
        else $display("FAIL model_read_data got %h expected %h at %0t", read_data, exp_rd, $time);
        total++;
        if (overflow_irq === exp_irq) passes++;
        else $display("FAIL model_irq got %b expected %b at %0t", overflow_irq, exp_irq, $time);
      end
      if (lit_req_seq != lit_done_seq) begin
        lit_done_seq = lit_req_seq;
        got = lit_is_irq ? {31'd0, overflow_irq} : read_data;
        total++;
        if (got === lit_exp) passes++;
        else $display("FAIL %s got %h expected %h", lit_name, got, lit_exp);
      end
    end
  end

  task automatic expect_lit(input string name, input bit is_irq, input logic [31:0] v);
    lit_name = name; lit_is_irq = is_irq; lit_exp = v;
    lit_req_seq++;
  endtask

  task automatic tick(input bit we, input bit re, input logic [31:0] a,
                      input logic [31:0] d, input logic [15:0] ev);
    @(negedge clk);
    write_en = we; read_en = re; address = a; write_data = d; perf_events = ev;
    @(posedge clk);
    model_step(we, re, a, d, ev);
    if (we) $display("write addr=%h data=%h events=%h", a, d, ev);
    if (re) $display("read  addr=%h expect=%h events=%h", a, exp_rd, ev);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [15:0] ev);
    tick(1'b1, 1'b0, a, d, ev);
  endtask

  task automatic rd(input logic [31:0] a, input logic [15:0] ev);
    tick(1'b0, 1'b1, a, 32'd0, ev);
  endtask

  task automatic idle(input logic [15:0] ev);
    tick(1'b0, 1'b0, 32'd0, 32'd0, ev);
  endtask

  function automatic logic [31:0] ca(input int n, input int r);
    return B + 32'(n * 16 + r * 4);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          sel;
    model_reset();
    repeat (2) @(posedge clk);
    #1 expect_lit("reset_read_data", 1'b0, 32'd0);
    @(posedge clk);
    #1 expect_lit("reset_irq", 1'b1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    // Ten matching pulses then five on a different line
    wr(ca(0, 0), 32'd3, 16'h0);
    wr(ca(0, 1), 32'd1, 16'h0);
    repeat (10) idle(16'h0008);
    repeat (5)  idle(16'h0004);
    rd(ca(0, 2), 16'h0);
    expect_lit("count_ten", 1'b0, 32'd10);
    rd(B + 32'h104, 16'h0);
    expect_lit("id_reg", 1'b0, 32'h3004_1001);

    // Wrap from all-ones, overflow flag and interrupt, then W1C
    wr(ca(0, 1), 32'd0, 16'h0);
    wr(ca(0, 0), 32'd0, 16'h0);
    wr(ca(0, 3), 32'h0000_FFFF, 16'h0);
    wr(ca(0, 2), 32'hFFFF_FFFE, 16'h0);
    wr(ca(0, 1), 32'd3, 16'h0);
    idle(16'h0001);
    idle(16'h0001);
    expect_lit("irq_lags_flag", 1'b1, 32'd0);
    idle(16'h0);
    expect_lit("irq_high", 1'b1, 32'd1);
    rd(ca(0, 2), 16'h0);
    expect_lit("wrapped_lo", 1'b0, 32'd0);
    rd(B + 32'h100, 16'h0);
    expect_lit("ovf_status", 1'b0, 32'd1);
    wr(B + 32'h100, 32'd1, 16'h0);
    expect_lit("irq_after_w1c_edge", 1'b1, 32'd1);
    idle(16'h0);
    expect_lit("irq_cleared", 1'b1, 32'd0);

    // Atomic wide read across a carry into the upper half
    wr(ca(0, 1), 32'd1, 16'h0);
    wr(ca(0, 3), 32'd0, 16'h0);
    wr(ca(0, 2), 32'hFFFF_FFFF, 16'h0);
    rd(ca(0, 2), 16'h0001);
    expect_lit("lo_pre_increment", 1'b0, 32'hFFFF_FFFF);
    rd(ca(0, 3), 16'h0);
    expect_lit("hi_snapshot", 1'b0, 32'd0);
    rd(ca(0, 3), 16'h0);
    expect_lit("hi_live", 1'b0, 32'd1);

    // Software write beats a same-cycle event
    wr(ca(1, 0), 32'd5, 16'h0);
    wr(ca(1, 1), 32'd1, 16'h0);
    wr(ca(1, 2), 32'd5, 16'h0020);
    rd(ca(1, 2), 16'h0);
    expect_lit("write_beats_event", 1'b0, 32'd5);

    // Out-of-range select never counts; unmapped offset reads zero
    wr(ca(2, 0), 32'd40, 16'h0);
    wr(ca(2, 1), 32'd1, 16'h0);
    repeat (100) idle(16'hFFFF);
    rd(ca(2, 2), 16'h0);
    expect_lit("sel40_no_count", 1'b0, 32'd0);
    rd(B + 32'h1F0, 16'h0);
    expect_lit("unmapped_1f0", 1'b0, 32'd0);

    // Random traffic checked against the model
    for (int i = 0; i < 2000; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) a = ca(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      else if (sel == 6) a = B + 32'h100;
      else if (sel == 7) a = B + 32'h104;
      else if (sel == 8) a = ($urandom_range(0, 1) == 0) ? B + 32'h1F0 : B + 32'h2;
      else a = 32'h0011_0200 + 32'($urandom_range(0, 3) * 16);
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'($urandom_range(0, 20));
        2: d = 32'hFFFF_FFFF;
        default: d = 32'hFFFF_FFF0;
      endcase
      case ($urandom_range(0, 3))
        0: idle(16'($urandom));
        1: wr(a, d, 16'($urandom));
        2: rd(a, 16'($urandom));
        default: begin
          sel = int'($urandom_range(0, 3));
          rd(ca(sel, 2), 16'($urandom));
          rd(ca(sel, 3), 16'($urandom));
        end
      endcase
    end
    idle(16'h0);

    // Reset landing between a read strobe and its data return
    @(negedge clk);
    read_en = 1'b1; address = ca(0, 2); perf_events = 16'hFFFF;
    #2;
    chk_en = 1'b0;
    reset = 1'b0;
    model_reset();
    expect_lit("reset_mid_read", 1'b0, 32'd0);
    @(posedge clk);
    #1 expect_lit("reset_mid_irq", 1'b1, 32'd0);
    read_en = 1'b0; address = '0; perf_events = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;

    // Nothing counts until software enables it again
    repeat (5) idle(16'hFFFF);
    rd(ca(0, 2), 16'h0);
    expect_lit("post_reset_lo", 1'b0, 32'd0);
    rd(ca(0, 0), 16'h0);
    expect_lit("post_reset_sel", 1'b0, 32'd0);
    rd(ca(0, 1), 16'h0);
    expect_lit("post_reset_ctl", 1'b0, 32'd0);
    rd(ca(3, 3), 16'h0);
    expect_lit("post_reset_hi", 1'b0, 32'd0);
    rd(B + 32'h100, 16'h0);
    expect_lit("post_reset_ovf", 1'b0, 32'd0);
    idle(16'h0);
    idle(16'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
